// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits: double-buffered
// display data with a frame-aligned load handshake, inter-digit blanking and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*DIGITS-1:0]   disp_val,
  input  logic [DIGITS-1:0]     disp_en,
  input  logic [DIGITS-1:0]     disp_dot,
  input  logic                  load,
  input  logic                  lz_sup,
  output logic                  load_ack,
  output logic [4:0]            seg_in,
  output logic                  seg_en,
  output logic                  dot,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame
);

  localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam int IW      = $clog2(DIGITS);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    pending;
  logic                    boundary;
  logic [DIGITS-1:0][4:0]  stg_val, act_val;
  logic [DIGITS-1:0]       stg_en, stg_dot, act_en, act_dot;
  logic [DIGITS-1:0]       sup;
  logic                    zero_run;
  logic [4:0]              seg_in_nxt;
  logic                    seg_en_nxt, dot_nxt, frame_nxt;
  logic [DIGITS-1:0]       dig_sel_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_BLANK;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = S_SHOW;
          cnt_nxt   = '0;
        end
      end
      S_SHOW: begin
        if (cnt == SCAN_LAST) begin
          state_nxt = S_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nxt = S_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Last lit cycle of the last digit: the only moment active data may be replaced.
  assign boundary = (state == S_SHOW) && (idx == IDX_LAST) && (cnt == SCAN_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_val  <= '0;
      stg_en   <= '0;
      stg_dot  <= '0;
      act_val  <= '0;
      act_en   <= '0;
      act_dot  <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= boundary & (pending | load);
      if (load) begin
        stg_val <= disp_val;
        stg_en  <= disp_en;
        stg_dot <= disp_dot;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          act_val <= disp_val;
          act_en  <= disp_en;
          act_dot <= disp_dot;
        end else if (pending) begin
          act_val <= stg_val;
          act_en  <= stg_en;
          act_dot <= stg_dot;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // A digit is suppressed when it and every more significant digit hold code zero.
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (act_val[i] == 5'd0);
      sup[i]   = lz_sup & zero_run;
    end
  end

  always_comb begin
    dig_sel_nxt = '1;
    seg_en_nxt  = 1'b0;
    dot_nxt     = 1'b0;
    seg_in_nxt  = seg_in;
    frame_nxt   = 1'b0;
    if (state_nxt == S_SHOW) begin
      dig_sel_nxt[idx_nxt] = 1'b0;
      seg_in_nxt = act_val[idx_nxt];
      dot_nxt    = act_dot[idx_nxt];
      seg_en_nxt = act_en[idx_nxt] & ~sup[idx_nxt];
      frame_nxt  = (idx_nxt == IDX_LAST) && (cnt_nxt == SCAN_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_in  <= '0;
      seg_en  <= 1'b0;
      dot     <= 1'b0;
      dig_sel <= '1;
      frame   <= 1'b0;
    end else begin
      seg_in  <= seg_in_nxt;
      seg_en  <= seg_en_nxt;
      dot     <= dot_nxt;
      dig_sel <= dig_sel_nxt;
      frame   <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios followed by random loads,
// suppression toggles and resets, compared every cycle against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int PER       = BLANK_CYC + SCAN_DIV;
  localparam int FRM       = DIGITS * PER;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [5*DIGITS-1:0]   disp_val = '0;
  logic [DIGITS-1:0]     disp_en = '0;
  logic [DIGITS-1:0]     disp_dot = '0;
  logic                  load = 1'b0;
  logic                  lz_sup = 1'b0;
  logic                  load_ack;
  logic [4:0]            seg_in;
  logic                  seg_en;
  logic                  dot;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame;

  seg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .disp_val(disp_val),
    .disp_en (disp_en),
    .disp_dot(disp_dot),
    .load    (load),
    .lz_sup  (lz_sup),
    .load_ack(load_ack),
    .seg_in  (seg_in),
    .seg_en  (seg_en),
    .dot     (dot),
    .dig_sel (dig_sel),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: k counts cycles since the last reset edge; everything follows from k mod FRM.
  int                k;
  logic [4:0]        act_val [DIGITS];
  logic [4:0]        stg_val [DIGITS];
  logic [DIGITS-1:0] act_en, act_dot, stg_en, stg_dot;
  bit                pend, ack_exp, lz_edge;
  logic [4:0]        last_seg;

  logic [4:0]        in_val [DIGITS];
  logic [DIGITS-1:0] in_en, in_dot;
  bit                in_load, in_lz, in_rst;
  bit                frame_load_done, rst_done;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  function automatic bit isFrame(input int kk);
    int p;
    p = kk % FRM;
    return (p / PER == DIGITS - 1) && (p % PER == PER - 1);
  endfunction

  function automatic logic [4:0] rndCode();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd16;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic modelReset();
    k = 0;
    for (int i = 0; i < DIGITS; i++) begin
      act_val[i] = '0;
      stg_val[i] = '0;
    end
    act_en = '0; act_dot = '0; stg_en = '0; stg_dot = '0;
    pend = 1'b0; ack_exp = 1'b0; lz_edge = 1'b0; last_seg = '0;
  endtask

  task automatic checkCycle();
    int p, d, r;
    bit lit, zrun, sup;
    logic [DIGITS-1:0] e_sel;
    p = k % FRM;
    d = p / PER;
    r = p % PER;
    lit = (r >= BLANK_CYC);
    sup = 1'b0;
    if (lit && lz_edge && d > 0) begin
      zrun = 1'b1;
      for (int j = d; j < DIGITS; j++)
        if (act_val[j] != 5'd0) zrun = 1'b0;
      sup = zrun;
    end
    e_sel = '1;
    if (lit) begin
      e_sel[d] = 1'b0;
      last_seg = act_val[d];
    end
    checkOutput("dig_sel", 32'(dig_sel), 32'(e_sel));
    checkOutput("seg_en", 32'(seg_en), lit ? 32'(act_en[d] & ~sup) : 32'd0);
    checkOutput("dot", 32'(dot), lit ? 32'(act_dot[d]) : 32'd0);
    checkOutput("seg_in", 32'(seg_in), 32'(last_seg));
    checkOutput("frame", 32'(frame), 32'(isFrame(k)));
    checkOutput("load_ack", 32'(load_ack), 32'(ack_exp));
  endtask

  task automatic randomData();
    for (int i = 0; i < DIGITS; i++) in_val[i] = rndCode();
    in_en  = DIGITS'($urandom);
    in_dot = DIGITS'($urandom);
  endtask

  task automatic applyStimulus(input int g);
    int p, d, r;
    bit frame_now, lit_now;
    p = k % FRM;
    d = p / PER;
    r = p % PER;
    frame_now = isFrame(k);
    lit_now   = (r >= BLANK_CYC);
    in_load = 1'b0;
    in_rst  = 1'b0;
    if (g < 400)
      in_lz = (g >= 85 && g < 125) || (g >= 265 && g < 310);
    else if ($urandom_range(0, 15) == 0)
      in_lz = ~in_lz;
    if (g == 45) begin
      in_val[3] = 5'd3; in_val[2] = 5'd2; in_val[1] = 5'd1; in_val[0] = 5'd0;
      in_en = '1; in_dot = 4'b0010; in_load = 1'b1;
    end else if (g == 85) begin
      in_val[3] = 5'd0; in_val[2] = 5'd0; in_val[1] = 5'd5; in_val[0] = 5'd0;
      in_en = '1; in_dot = '0; in_load = 1'b1;
    end else if (g == 165 || g == 170) begin
      randomData();
      in_load = 1'b1;
    end else if (g >= 200 && g < 260 && frame_now && !frame_load_done) begin
      randomData();
      in_load = 1'b1;
      frame_load_done = 1'b1;
    end else if (g == 265) begin
      in_val[3] = 5'd16; in_val[2] = 5'd0; in_val[1] = 5'd0; in_val[0] = 5'd0;
      in_en = '1; in_dot = '0; in_load = 1'b1;
    end else if (g == 330) begin
      randomData();
      in_load = 1'b1;
    end else if (g > 330 && g < 400 && !rst_done && d == 2 && lit_now) begin
      in_rst   = 1'b1;
      rst_done = 1'b1;
    end else if (g >= 400) begin
      in_load = ($urandom_range(0, 7) == 0) || (frame_now && $urandom_range(0, 1) == 1);
      if (in_load) randomData();
      in_rst = ($urandom_range(0, 249) == 0);
    end
    rst_n    = ~in_rst;
    load     = in_load;
    lz_sup   = in_lz;
    disp_en  = in_en;
    disp_dot = in_dot;
    for (int i = 0; i < DIGITS; i++) disp_val[5*i +: 5] = in_val[i];
  endtask

  task automatic modelEdge();
    bit frame_now;
    if (in_rst) begin
      modelReset();
    end else begin
      frame_now = isFrame(k);
      ack_exp   = frame_now && (pend || in_load);
      if (frame_now && in_load) begin
        for (int i = 0; i < DIGITS; i++) act_val[i] = in_val[i];
        act_en = in_en; act_dot = in_dot; pend = 1'b0;
      end else if (frame_now && pend) begin
        for (int i = 0; i < DIGITS; i++) act_val[i] = stg_val[i];
        act_en = stg_en; act_dot = stg_dot; pend = 1'b0;
      end else if (in_load) begin
        for (int i = 0; i < DIGITS; i++) stg_val[i] = in_val[i];
        stg_en = in_en; stg_dot = in_dot; pend = 1'b1;
      end
      lz_edge = in_lz;
      k++;
    end
  endtask

  initial begin
    for (int i = 0; i < DIGITS; i++) in_val[i] = '0;
    in_en = '0; in_dot = '0; in_load = 1'b0; in_lz = 1'b0; in_rst = 1'b0;
    frame_load_done = 1'b0;
    rst_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();
    for (int g = 0; g < 1500; g++) begin
      @(negedge clk);
      checkCycle();
      applyStimulus(g);
      modelEdge();
    end
    @(negedge clk);
    checkCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- Shares the single 5-bit-code to segment-pattern converter between DIGITS digits; drives the converter's SEG_IN, SEG_EN and DOT inputs plus the digit-select lines.
- Double-buffers display data with a LOAD/LOAD_ACK handshake, so frames update atomically and never tear mid-scan.
- Inserts blanking between digits (anti-ghosting) and optionally suppresses leading zeros.

Parameters:
- DIGITS, 4: number of digits scanned (>=2).
- SCAN_DIV, 50000: CLK cycles each digit is lit (>=2).
- BLANK_CYC, 500: CLK cycles all digits are off between digits (>=1).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, synchronous, active-low
- DISP_VAL  in  5*DIGITS  digit i code at [5i+4:5i]; 0..15 = hex, 16 = minus; digit 0 is least significant/rightmost
- DISP_EN  in  DIGITS  per-digit segment enable
- DISP_DOT  in  DIGITS  per-digit decimal point
- LOAD  in  1  1-cycle strobe: capture DISP_* into staging
- LZ_SUP  in  1  leading-zero suppression enable (sampled live)
- LOAD_ACK  out  1  1-cycle pulse: staging copied to active
- SEG_IN  out  5  code to converter
- SEG_EN  out  1  enable to converter
- DOT  out  1  dot to converter
- DIG_SEL  out  DIGITS  active-low one-hot digit drive
- FRAME  out  1  1-cycle pulse, last cycle of a frame

Behaviour:
- All outputs are registered and change on the same edge as the state/counter registers.
- Reset (RST_N=0 at a CLK edge):
  - state=S_BLANK, idx=0, cnt=0, pending=0.
  - staging and active VAL/EN/DOT = 0.
  - SEG_IN=0, SEG_EN=0, DOT=0, DIG_SEL=all 1, FRAME=0, LOAD_ACK=0.
  - Reset mid-frame aborts immediately; any pending load is discarded.
- FSM:
  - S_BLANK: lasts BLANK_CYC cycles. DIG_SEL all 1, SEG_EN=0, DOT=0, SEG_IN holds. When cnt=BLANK_CYC-1: go to S_SHOW, cnt=0.
  - S_SHOW: lasts SCAN_DIV cycles. DIG_SEL[idx]=0, all other bits 1. SEG_IN=active_val[idx], DOT=active_dot[idx], SEG_EN=active_en[idx] & ~sup(idx).
  - S_SHOW exit: when cnt=SCAN_DIV-1, go to S_BLANK, cnt=0, idx=(idx==DIGITS-1)?0:idx+1.
- Scan order and timing:
  - Digits are scanned 0,1,..,DIGITS-1, then wrap to 0.
  - First lit cycle of digit 0 is BLANK_CYC cycles after reset release.
  - Frame period = DIGITS*(BLANK_CYC+SCAN_DIV).
- FRAME pulses high in the final S_SHOW cycle of digit DIGITS-1 (the frame boundary).
- Load handshake:
  - LOAD=1: staging <= DISP_VAL/EN/DOT, pending <= 1.
  - LOAD while pending: staging is overwritten (last write wins); exactly one ACK is issued.
  - At the frame boundary with pending=1: active <= staging, pending <= 0, LOAD_ACK=1 on the next cycle.
  - LOAD coinciding with the frame boundary: active <= the DISP_* inputs of that cycle directly, pending=0, LOAD_ACK next cycle.
  - Active data never changes except at a frame boundary.
- Leading-zero suppression:
  - sup(i)=1 iff LZ_SUP=1, i>0, and active_val[j]==5'd0 for every j in i..DIGITS-1.
  - Digit 0 is never suppressed.
  - Codes other than exactly 0 (including 16) are never suppressed.
  - DOT is not affected by suppression or by EN.
- Codes 17..31 are passed through unchanged; the converter handles them.

Test Plan (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1):
- Reset, release, idle 40 cycles:
  - DIG_SEL sequence per 5 cycles: 1111, 1110 x4, 1111, 1101 x4, ... through 0111.
  - FRAME every 20 cycles, on the 4th 0111 cycle; SEG_EN=0 throughout.
- LOAD VAL={3,2,1,0}, EN=1111, DOT=0010 mid-frame:
  - Outputs unchanged until the frame boundary; LOAD_ACK one cycle after FRAME.
  - Next frame: SEG_IN=0,1,2,3 per digit, DOT=1 only while DIG_SEL=1101.
- LZ_SUP=1, VAL={0,0,5,0}, EN=1111:
  - SEG_EN=1 for digits 0 and 1, 0 for digits 2 and 3.
  - With LZ_SUP=0: SEG_EN=1 for all digits.
- Two LOADs in one frame (A then B), plus a LOAD exactly on the FRAME cycle in a later frame:
  - Only B is displayed; a single LOAD_ACK pulse.
  - LOAD on the FRAME cycle is displayed in the immediately following frame.
- VAL digit 3 = 16, LZ_SUP=1: digit 3 SEG_IN=16 with SEG_EN=1; digits below it are not suppressed.
- Assert RST_N=0 for 1 cycle during S_SHOW of digit 2 with a load pending:
  - All outputs return to their reset values; no LOAD_ACK.
  - Display blank; scan restarts at digit 0 after BLANK_CYC.
